// File: rtl/regfile_wb_pkg.sv
// Shared types for the Wishbone debug port into the RV32 register file:
// FSM encoding, address field positions and the byte-lane merge used by partial writes.
package regfile_wb_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HALT_WAIT = 3'd1,
        READ      = 3'd2,
        WRITE     = 3'd3,
        ACK       = 3'd4,
        ERR       = 3'd5
    } state_t;

    localparam int IDX_LSB   = 2;
    localparam int IDX_MSB   = 6;
    localparam int SPACE_BIT = 7;

    function automatic logic [31:0] merge_lanes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  sel
    );
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_wb_port.sv
// Wishbone classic slave for debug access to x0..x31; halts the core, then read or read-modify-write.
// Read ack 3 cycles after stb, write ack 4, plus one per halt-wait cycle; no pipelining, cyc drop aborts.
module regfile_wb_port
    import regfile_wb_pkg::*;
#(
    parameter int HALT_TIMEOUT = 255,
    parameter int ADDR_W       = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [ADDR_W-1:0] wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    input  logic [3:0]        wb_sel_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic              cpu_halt_req_o,
    input  logic              cpu_halt_ack_i,
    output logic [4:0]        rf_a_o,
    input  logic [31:0]       rf_rd_i,
    output logic [4:0]        rf_a3_o,
    output logic [31:0]       rf_wd3_o,
    output logic              rf_we3_o
);

    localparam int              CNT_W    = $clog2(HALT_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALT_TIMEOUT - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [4:0]       idx_q;
    logic             we_q;
    logic [3:0]       sel_q;
    logic [31:0]      dat_q;
    logic [31:0]      merged_q;
    logic [31:0]      rdat_q;
    logic             req;
    logic             unused_adr;

    assign req        = wb_cyc_i & wb_stb_i;
    // Bits [1:0] and anything above SPACE_BIT carry no meaning here.
    assign unused_adr = ^wb_adr_i;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == HALT_WAIT && state_d == HALT_WAIT) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                cnt_q <= '0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = wb_adr_i[SPACE_BIT] ? ERR : HALT_WAIT;
                end
            end
            HALT_WAIT: begin
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                end else if (cpu_halt_ack_i) begin
                    state_d = READ;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ERR;
                end
            end
            READ: begin
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = we_q ? WRITE : ACK;
                end
            end
            WRITE:   state_d = ACK;
            ACK:     state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx_q    <= '0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            dat_q    <= '0;
            merged_q <= '0;
            rdat_q   <= '0;
        end else begin
            if (state_q == IDLE && req) begin
                idx_q <= wb_adr_i[IDX_MSB:IDX_LSB];
                we_q  <= wb_we_i;
                sel_q <= wb_sel_i;
                dat_q <= wb_dat_i;
            end
            if (state_q == READ && wb_cyc_i) begin
                if (we_q) begin
                    merged_q <= merge_lanes(rf_rd_i, dat_q, sel_q);
                end else begin
                    // x0 is architecturally zero whatever the array cell holds.
                    rdat_q <= (idx_q == 5'd0) ? 32'd0 : rf_rd_i;
                end
            end
        end
    end

    always_comb begin
        wb_ack_o       = 1'b0;
        wb_err_o       = 1'b0;
        cpu_halt_req_o = 1'b0;
        rf_a_o         = '0;
        rf_a3_o        = '0;
        rf_wd3_o       = '0;
        rf_we3_o       = 1'b0;
        case (state_q)
            HALT_WAIT: cpu_halt_req_o = 1'b1;
            READ: begin
                cpu_halt_req_o = 1'b1;
                rf_a_o         = idx_q;
            end
            WRITE: begin
                cpu_halt_req_o = 1'b1;
                rf_a3_o        = idx_q;
                rf_wd3_o       = merged_q;
                rf_we3_o       = (idx_q != 5'd0) && (sel_q != 4'b0000);
            end
            ACK: begin
                cpu_halt_req_o = 1'b1;
                wb_ack_o       = 1'b1;
            end
            ERR:     wb_err_o = 1'b1;
            default: ;
        endcase
    end

    assign wb_dat_o = rdat_q;

endmodule

// File: tb/tb_regfile_wb_port.sv
// Directed bench for regfile_wb_port: behavioural register file, cycle-counted Wishbone accesses.
module tb_regfile_wb_port;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_we_i = 1'b0;
    logic [7:0]  wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [3:0]  wb_sel_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        cpu_halt_req_o;
    logic        cpu_halt_ack_i = 1'b1;
    logic [4:0]  rf_a_o;
    logic [31:0] rf_rd_i;
    logic [4:0]  rf_a3_o;
    logic [31:0] rf_wd3_o;
    logic        rf_we3_o;

    always #5 clk = ~clk;

    regfile_wb_port #(.HALT_TIMEOUT(4), .ADDR_W(8)) dut (
        .clk(clk), .resetn(resetn),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .cpu_halt_req_o(cpu_halt_req_o), .cpu_halt_ack_i(cpu_halt_ack_i),
        .rf_a_o(rf_a_o), .rf_rd_i(rf_rd_i),
        .rf_a3_o(rf_a3_o), .rf_wd3_o(rf_wd3_o), .rf_we3_o(rf_we3_o)
    );

    // Behavioural register file; cell 0 holds junk so the port must force x0 reads to zero.
    logic [31:0] rf [32];
    assign rf_rd_i = rf[rf_a_o];

    int          total = 0;
    int          bad = 0;
    int          we3_cnt = 0;
    logic [4:0]  last_a3 = '0;
    logic [31:0] last_wd3 = '0;
    logic        halt_seen = 1'b0;

    always @(negedge clk) begin
        if (rf_we3_o) begin
            we3_cnt++;
            last_a3  = rf_a3_o;
            last_wd3 = rf_wd3_o;
            rf[rf_a3_o] = rf_wd3_o;
        end
        if (cpu_halt_req_o) halt_seen = 1'b1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Cycle 0 is the clock where the slave samples stb; ack/err cycle numbers count from there.
    task automatic wb_access(input logic we, input logic [7:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, output int ack_cyc, output int err_cyc,
                             output logic [31:0] rdat);
        ack_cyc = -1;
        err_cyc = -1;
        rdat    = '0;
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (wb_ack_o) begin ack_cyc = n; rdat = wb_dat_o; break; end
            if (wb_err_o) begin err_cyc = n; break; end
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    int          ack_c;
    int          err_c;
    int          w0;
    int          seen;
    logic [31:0] rd;

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0101_0101 * i;
        rf[0] = 32'h5A5A_5A5A;
        rf[5] = 32'hDEAD_BEEF;
        rf[7] = 32'hAABB_CCDD;

        repeat (2) @(negedge clk);
        check_val("reset_ctrl", {wb_ack_o, wb_err_o, cpu_halt_req_o, rf_we3_o, rf_a_o, rf_a3_o}, 32'd0);
        check_val("reset_dat_o", wb_dat_o, 32'd0);
        check_val("reset_wd3", rf_wd3_o, 32'd0);
        resetn = 1'b1;

        w0 = we3_cnt;
        wb_access(1'b0, 8'h14, 32'd0, 4'hF, ack_c, err_c, rd);
        check_val("rd_x5_ack_cyc", ack_c, 3);
        check_val("rd_x5_data", rd, 32'hDEAD_BEEF);
        check_val("rd_x5_no_we3", we3_cnt - w0, 0);

        w0 = we3_cnt;
        wb_access(1'b1, 8'h28, 32'h1234_5678, 4'hF, ack_c, err_c, rd);
        check_val("wr_x10_ack_cyc", ack_c, 4);
        check_val("wr_x10_we3_pulses", we3_cnt - w0, 1);
        check_val("wr_x10_a3", last_a3, 5'd10);
        check_val("wr_x10_wd3", last_wd3, 32'h1234_5678);

        w0 = we3_cnt;
        wb_access(1'b1, 8'h1C, 32'h1122_3344, 4'b0101, ack_c, err_c, rd);
        check_val("bsel_we3_pulses", we3_cnt - w0, 1);
        check_val("bsel_wd3", last_wd3, 32'hAA22_CC44);
        wb_access(1'b0, 8'h1C, 32'd0, 4'hF, ack_c, err_c, rd);
        check_val("bsel_readback", rd, 32'hAA22_CC44);

        w0 = we3_cnt;
        wb_access(1'b1, 8'h00, 32'hFFFF_FFFF, 4'hF, ack_c, err_c, rd);
        check_val("x0_wr_ack_cyc", ack_c, 4);
        check_val("x0_wr_no_we3", we3_cnt - w0, 0);
        wb_access(1'b0, 8'h00, 32'd0, 4'hF, ack_c, err_c, rd);
        check_val("x0_rd_zero", rd, 32'd0);

        w0 = we3_cnt;
        wb_access(1'b1, 8'h28, 32'hCAFE_F00D, 4'h0, ack_c, err_c, rd);
        check_val("sel0_ack_cyc", ack_c, 4);
        check_val("sel0_no_we3", we3_cnt - w0, 0);
        wb_access(1'b0, 8'h28, 32'd0, 4'hF, ack_c, err_c, rd);
        check_val("sel0_readback", rd, 32'h1234_5678);

        @(negedge clk);
        halt_seen = 1'b0;
        wb_access(1'b0, 8'h80, 32'd0, 4'hF, ack_c, err_c, rd);
        check_val("space_err_cyc", err_c, 1);
        check_val("space_no_halt", halt_seen, 1'b0);

        cpu_halt_ack_i = 1'b0;
        wb_access(1'b0, 8'h0C, 32'd0, 4'hF, ack_c, err_c, rd);
        check_val("tmo_err_cyc", err_c, 5);
        check_val("tmo_no_ack", ack_c, -1);
        @(negedge clk);
        check_val("tmo_released", {cpu_halt_req_o, wb_err_o}, 2'b00);
        cpu_halt_ack_i = 1'b1;
        wb_access(1'b0, 8'h14, 32'd0, 4'hF, ack_c, err_c, rd);
        check_val("tmo_then_rd_cyc", ack_c, 3);
        check_val("tmo_then_rd_data", rd, 32'hDEAD_BEEF);

        cpu_halt_ack_i = 1'b0;
        w0 = we3_cnt;
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = 8'h14; wb_dat_i = 32'h0; wb_sel_i = 4'hF;
        @(negedge clk);
        check_val("abort_halt_req_on", cpu_halt_req_o, 1'b1);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(negedge clk);
        check_val("abort_halt_req_off", cpu_halt_req_o, 1'b0);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (wb_ack_o || wb_err_o) seen++;
        end
        check_val("abort_no_term", seen, 0);
        check_val("abort_no_we3", we3_cnt - w0, 0);
        check_val("abort_rf_intact", rf[5], 32'hDEAD_BEEF);

        cpu_halt_ack_i = 1'b1;
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
        wb_adr_i = 8'h14; wb_sel_i = 4'hF;
        @(negedge clk);
        @(negedge clk);
        check_val("rst_mid_read_a", rf_a_o, 5'd5);
        #2 resetn = 1'b0;
        #1;
        check_val("rst_async_ctrl", {wb_ack_o, wb_err_o, cpu_halt_req_o, rf_we3_o, rf_a_o, rf_a3_o}, 32'd0);
        check_val("rst_async_dat", wb_dat_o, 32'd0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (wb_ack_o || wb_err_o || cpu_halt_req_o) seen++;
        end
        check_val("rst_quiet_after", seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_port.md
Name: regfile_wb_port

Overview:
Wishbone B4 classic slave that gives the external debug/bus master read and write access to the 32 RV32 general-purpose registers. It is the initiator on the register file ports: it drives the read address and samples the read data, and it drives a3/wd3/we3.
- Before each access it requests a CPU halt through a req/ack handshake.
- Byte-select writes are done as read-modify-write.
- It sits beside the multi-cycle core on the shared Wishbone fabric.

Parameters:
HALT_TIMEOUT, 255, cycles to wait in HALT_WAIT for cpu_halt_ack_i before the access terminates with wb_err_o
ADDR_W, 8, width of wb_adr_i

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
wb_cyc_i  in  1  bus cycle valid
wb_stb_i  in  1  strobe
wb_we_i  in  1  1=write, 0=read
wb_adr_i  in  ADDR_W  byte address; [6:2]=register index, [7]=must be 0, [1:0] ignored
wb_dat_i  in  32  write data
wb_sel_i  in  4  byte lane enables
wb_dat_o  out  32  read data, valid while wb_ack_o=1
wb_ack_o  out  1  normal termination, 1-cycle pulse
wb_err_o  out  1  error termination, 1-cycle pulse
cpu_halt_req_o  out  1  request core to stall at an instruction boundary
cpu_halt_ack_i  in  1  core stalled, register file ports free
rf_a_o  out  5  register file read address
rf_rd_i  in  32  register file read data, combinational from rf_a_o
rf_a3_o  out  5  register file write address
rf_wd3_o  out  32  register file write data
rf_we3_o  out  1  register file write enable

Behaviour:
Reset (resetn=0, asynchronous):
- state=IDLE, timeout counter=0.
- All outputs 0.

State machine, one transition per clk:
- IDLE:
  - On wb_cyc_i&wb_stb_i: latch adr/we/sel/dat.
  - If adr[7]=1: go to ERR without halting the core.
  - Otherwise assert cpu_halt_req_o and go to HALT_WAIT.
- HALT_WAIT:
  - cpu_halt_ack_i=1: go to READ, drive rf_a_o=idx.
  - cpu_halt_ack_i=0: counter++; at counter==HALT_TIMEOUT go to ERR.
- READ:
  - Capture rf_rd_i.
  - Read access: wb_dat_o<=rf_rd_i, go to ACK.
  - Write access: build merged = per byte lane, sel[i] ? dat_i byte : rf_rd_i byte, then go to WRITE.
- WRITE:
  - rf_a3_o=idx, rf_wd3_o=merged, rf_we3_o=1 for exactly this cycle.
  - Suppress the write (rf_we3_o=0) if idx==0 or sel==4'b0000.
  - Go to ACK.
- ACK:
  - wb_ack_o=1 for one cycle.
  - cpu_halt_req_o deasserts on entry to IDLE.
  - wb_dat_o is held until the next access.
- ERR:
  - wb_err_o=1 for one cycle, halt_req dropped, go to IDLE.

Latency:
- Stb is sampled in IDLE at cycle 0. With cpu_halt_ack_i already 1, read ack arrives at cycle 3 and write ack at cycle 4.
- Each cycle of halt wait adds one cycle.

Boundary conditions:
- Abort: wb_cyc_i=0 in HALT_WAIT or READ → go to IDLE immediately, drop halt_req, no rf write, no ack. Once in WRITE, the write completes and the ack is still issued.
- Reads of x0 return 0.
- The counter clears whenever the FSM leaves HALT_WAIT.
- cpu_halt_ack_i dropping after READ is a core protocol violation and is ignored.
- Back-to-back accesses: a new stb is accepted only in IDLE. No pipelining; stb held high after ack starts a fresh access.
- Reset mid-access: everything returns to IDLE, no ack and no err is issued, and a write in progress is dropped.

Decomposition:
- Package regfile_wb_pkg holds:
  - FSM state encoding: IDLE, HALT_WAIT, READ, WRITE, ACK, ERR.
  - Address field constants: IDX_LSB=2, IDX_MSB=6, SPACE_BIT=7.
- No sub-module is required. Optionally, the byte-lane merge can be a small combinational function in the package.

Test Plan:
- Read: halt_ack tied 1, rf holds x5=32'hDEADBEEF, read adr 8'h14 → ack at cycle 3, wb_dat_o=32'hDEADBEEF, rf_we3_o never 1.
- Full-word write: write adr 8'h28, sel 4'hF, dat 32'h12345678 → one-cycle rf_we3_o with rf_a3_o=10, wd3=32'h12345678; ack at cycle 4.
- Byte-select write: x7=32'hAABBCCDD, write sel 4'b0101, dat 32'h11223344 → wd3=32'hAA22CC44.
- x0: write 32'hFFFFFFFF to adr 8'h00 → ack issued, rf_we3_o stays 0; a following read returns 0.
- Errors:
  - adr 8'h80 → wb_err_o at cycle 1, halt_req never asserted.
  - halt_ack held 0 with HALT_TIMEOUT=4 → wb_err_o, halt_req released, FSM back in IDLE.
- Abort and reset:
  - Drop wb_cyc_i during HALT_WAIT → no ack/err/we3, halt_req cleared next cycle.
  - resetn pulsed mid-READ → all outputs 0 asynchronously.
